// File: rtl/mips_alu_muldiv_seq_pkg.sv
// Shared types for the MIPS EX-stage multiply/divide sequencer: ALU func
// encodings, sequencer state, step-datapath mode and the clock/reset bundle.
package mips_alu_muldiv_seq_pkg;

    typedef struct packed {
        logic clk;
        logic rst_n;
    } Data_Control_T;

    typedef enum logic [3:0] {
        FUNC_ADD  = 4'd0,
        FUNC_SUB  = 4'd1,
        FUNC_AND  = 4'd2,
        FUNC_OR   = 4'd3,
        FUNC_XOR  = 4'd4,
        FUNC_SLT  = 4'd5,
        FUNC_MULU = 4'd6,
        FUNC_MULS = 4'd7,
        FUNC_DIVU = 4'd8,
        FUNC_DIVS = 4'd9,
        FUNC_MTHI = 4'd10,
        FUNC_MTLO = 4'd11,
        FUNC_MFHI = 4'd12,
        FUNC_MFLO = 4'd13
    } Mips_Alu_Func_T;

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'd0,
        MULDIV_RUN  = 2'd1,
        MULDIV_FIX  = 2'd2
    } Mips_Alu_MulDiv_State;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } Mips_Alu_Step_Mode;

    // Ceiling log2, usable in parameter defaults.
    function automatic int Util_Math_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mips_alu_muldiv_seq_if.sv
// Request/response bundle between the EX-stage pipeline (master) and the
// multiply/divide sequencer (slave).
interface mips_alu_muldiv_seq_if
    import mips_alu_muldiv_seq_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    Mips_Alu_Func_T    func;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              busy;

    modport master (
        output req_valid, func, data1, data2,
        input  req_ready, result, result_valid, busy
    );

    modport slave (
        input  req_valid, func, data1, data2,
        output req_ready, result, result_valid, busy
    );
endinterface

// File: rtl/mips_alu_muldiv_seq_step.sv
// One iteration of the unsigned multiply (shift-add) or divide (restoring
// subtract) datapath on a 2*DATA_W accumulator.
module mips_alu_muldiv_step
    import mips_alu_muldiv_seq_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic [2*DATA_W-1:0] acc,
    input  logic [DATA_W-1:0]   operand,
    input  Mips_Alu_Step_Mode   mode,
    output logic [2*DATA_W-1:0] acc_next
);
    logic [DATA_W:0] add_sum;
    logic [DATA_W:0] shifted_rem;
    logic [DATA_W:0] diff;
    logic            no_borrow;

    always_comb begin
        add_sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, operand};
        shifted_rem = acc[2*DATA_W-1:DATA_W-1];
        diff        = shifted_rem - {1'b0, operand};
        no_borrow   = (shifted_rem >= {1'b0, operand});
        acc_next    = acc;
        if (mode == STEP_MUL) begin
            // Multiplier sits in the low half and is consumed LSB first.
            if (acc[0])
                acc_next = {add_sum, acc[DATA_W-1:1]};
            else
                acc_next = {1'b0, acc[2*DATA_W-1:1]};
        end else begin
            // Remainder in the high half, dividend/quotient bits in the low half.
            if (no_borrow)
                acc_next = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            else
                acc_next = {shifted_rem[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/mips_alu_muldiv_seq.sv
// Iterative multiply/divide sequencer owning HI/LO; stalls the pipeline via
// req_ready while an operation is in flight.
module mips_alu_muldiv_seq
    import mips_alu_muldiv_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = Util_Math_log2(DATA_W) + 1
)(
    input Data_Control_T         ctrl,
    mips_alu_muldiv_seq_if.slave bus
);
    localparam int ACC_W = 2 * DATA_W;

    Mips_Alu_MulDiv_State state_reg;
    logic [DATA_W-1:0]    hi_reg;
    logic [DATA_W-1:0]    lo_reg;
    logic [DATA_W-1:0]    operand_reg;
    logic [DATA_W-1:0]    result_reg;
    logic [ACC_W-1:0]     acc_reg;
    logic [ACC_W-1:0]     acc_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 is_div_reg;
    logic                 neg_q_reg;
    logic                 neg_r_reg;
    logic                 busy_reg;
    logic                 result_valid_reg;

    logic                 accept;
    logic                 is_muldiv;
    logic                 is_signed;
    logic                 is_div_op;
    logic [DATA_W-1:0]    mag1;
    logic [DATA_W-1:0]    mag2;
    logic [ACC_W-1:0]     prod_fix;
    logic [DATA_W-1:0]    quot_fix;
    logic [DATA_W-1:0]    rem_fix;
    Mips_Alu_Step_Mode    step_mode;

    assign bus.req_ready    = (state_reg == MULDIV_IDLE);
    assign bus.result       = result_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.busy         = busy_reg;
    assign accept           = bus.req_valid && bus.req_ready;
    assign step_mode        = is_div_reg ? STEP_DIV : STEP_MUL;

    always_comb begin
        is_muldiv = 1'b0;
        is_signed = 1'b0;
        is_div_op = 1'b0;
        case (bus.func)
            FUNC_MULU: is_muldiv = 1'b1;
            FUNC_MULS: begin is_muldiv = 1'b1; is_signed = 1'b1; end
            FUNC_DIVU: begin is_muldiv = 1'b1; is_div_op = 1'b1; end
            FUNC_DIVS: begin is_muldiv = 1'b1; is_signed = 1'b1; is_div_op = 1'b1; end
            default: ;
        endcase
        mag1 = (is_signed && bus.data1[DATA_W-1]) ? -bus.data1 : bus.data1;
        mag2 = (is_signed && bus.data2[DATA_W-1]) ? -bus.data2 : bus.data2;
    end

    // Sign fixup applied to the magnitude result in the FIX cycle.
    always_comb begin
        prod_fix = neg_q_reg ? -acc_reg : acc_reg;
        quot_fix = neg_q_reg ? -acc_reg[DATA_W-1:0] : acc_reg[DATA_W-1:0];
        rem_fix  = neg_r_reg ? -acc_reg[ACC_W-1:DATA_W] : acc_reg[ACC_W-1:DATA_W];
    end

    mips_alu_muldiv_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .acc      (acc_reg),
        .operand  (operand_reg),
        .mode     (step_mode),
        .acc_next (acc_next)
    );

    always_ff @(posedge ctrl.clk) begin
        if (!ctrl.rst_n) begin
            state_reg        <= MULDIV_IDLE;
            hi_reg           <= '0;
            lo_reg           <= '0;
            operand_reg      <= '0;
            result_reg       <= '0;
            acc_reg          <= '0;
            cnt_reg          <= '0;
            is_div_reg       <= 1'b0;
            neg_q_reg        <= 1'b0;
            neg_r_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                MULDIV_IDLE: begin
                    if (accept && is_muldiv) begin
                        acc_reg     <= is_div_op ? {{DATA_W{1'b0}}, mag1} : {{DATA_W{1'b0}}, mag2};
                        operand_reg <= is_div_op ? mag2 : mag1;
                        is_div_reg  <= is_div_op;
                        neg_q_reg   <= is_signed && (bus.data1[DATA_W-1] ^ bus.data2[DATA_W-1]);
                        neg_r_reg   <= is_signed && is_div_op && bus.data1[DATA_W-1];
                        cnt_reg     <= CNT_W'(DATA_W - 1);
                        busy_reg    <= 1'b1;
                        state_reg   <= MULDIV_RUN;
                    end else if (accept) begin
                        case (bus.func)
                            FUNC_MTHI: hi_reg <= bus.data1;
                            FUNC_MTLO: lo_reg <= bus.data1;
                            FUNC_MFHI: begin result_reg <= hi_reg; result_valid_reg <= 1'b1; end
                            FUNC_MFLO: begin result_reg <= lo_reg; result_valid_reg <= 1'b1; end
                            default: ;
                        endcase
                    end
                end
                MULDIV_RUN: begin
                    acc_reg <= acc_next;
                    if (cnt_reg == '0)
                        state_reg <= MULDIV_FIX;
                    else
                        cnt_reg <= cnt_reg - 1'b1;
                end
                MULDIV_FIX: begin
                    if (is_div_reg) begin
                        lo_reg <= quot_fix;
                        hi_reg <= rem_fix;
                    end else begin
                        {hi_reg, lo_reg} <= prod_fix;
                    end
                    busy_reg  <= 1'b0;
                    state_reg <= MULDIV_IDLE;
                end
                default: state_reg <= MULDIV_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_alu_muldiv_seq.sv
// Directed-vector bench for the multiply/divide sequencer at DATA_W=8.
module tb_mips_alu_muldiv_seq;
    import mips_alu_muldiv_seq_pkg::*;

    localparam int DATA_W = 8;
    localparam int BOUND  = 60;

    logic          clk;
    logic          rst_n;
    Data_Control_T ctrl;
    int            vectors;
    int            miscompares;

    assign ctrl = '{clk: clk, rst_n: rst_n};

    mips_alu_muldiv_seq_if #(.DATA_W(DATA_W)) bus ();

    mips_alu_muldiv_seq #(.DATA_W(DATA_W)) dut (
        .ctrl (ctrl),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue(input Mips_Alu_Func_T f, input logic [7:0] a, input logic [7:0] b,
                         output int waited);
        int n;
        n = 0;
        bus.func = f; bus.data1 = a; bus.data2 = b; bus.req_valid = 1'b1;
        while (!bus.req_ready && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        waited = n;
    endtask

    task automatic muldiv(input string tag, input Mips_Alu_Func_T f,
                          input logic [7:0] a, input logic [7:0] b);
        int n, w;
        logic ready_seen;
        issue(f, a, b, w);
        n = 0;
        ready_seen = 1'b0;
        while (bus.busy && n < BOUND) begin
            if (bus.req_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_busy_cycles"}, n, DATA_W + 1);
        check({tag, "_ready_low"}, ready_seen, 1'b0);
        $display("op %s d1=0x%02h d2=0x%02h busy=%0d cycles", tag, a, b, n);
    endtask

    task automatic read(input string tag, input Mips_Alu_Func_T f, input logic [7:0] exp,
                        output int waited);
        issue(f, 8'h00, 8'h00, waited);
        check({tag, "_valid"}, bus.result_valid, 1'b1);
        check(tag, bus.result, exp);
        $display("read %s result=0x%02h (expect 0x%02h)", tag, bus.result, exp);
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, bus.result_valid, 1'b0);
    endtask

    initial begin
        int w;
        vectors = 0;
        miscompares = 0;
        bus.req_valid = 1'b0;
        bus.func = FUNC_ADD;
        bus.data1 = '0;
        bus.data2 = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_busy", bus.busy, 1'b0);
        check("rst_ready", bus.req_ready, 1'b1);
        check("rst_result_valid", bus.result_valid, 1'b0);
        check("rst_result", bus.result, 8'h00);
        read("rst_hi", FUNC_MFHI, 8'h00, w);
        read("rst_lo", FUNC_MFLO, 8'h00, w);

        muldiv("muls_m3x5", FUNC_MULS, 8'hFD, 8'h05);
        check("muls_ready_back", bus.req_ready, 1'b1);
        read("muls_hi", FUNC_MFHI, 8'hFF, w);
        read("muls_lo", FUNC_MFLO, 8'hF1, w);

        muldiv("divs_m7d2", FUNC_DIVS, 8'hF9, 8'h02);
        read("divs_lo", FUNC_MFLO, 8'hFD, w);
        read("divs_hi", FUNC_MFHI, 8'hFF, w);

        muldiv("divu_7d0", FUNC_DIVU, 8'h07, 8'h00);
        read("divu0_lo", FUNC_MFLO, 8'hFF, w);
        read("divu0_hi", FUNC_MFHI, 8'h07, w);

        muldiv("divs_m7d0", FUNC_DIVS, 8'hF9, 8'h00);
        read("divs0_lo", FUNC_MFLO, 8'h01, w);
        read("divs0_hi", FUNC_MFHI, 8'hF9, w);

        muldiv("divs_ovf", FUNC_DIVS, 8'h80, 8'hFF);
        read("ovf_lo", FUNC_MFLO, 8'h80, w);
        read("ovf_hi", FUNC_MFHI, 8'h00, w);

        muldiv("divu_200d7", FUNC_DIVU, 8'hC8, 8'h07);
        read("divu_lo", FUNC_MFLO, 8'h1C, w);
        read("divu_hi", FUNC_MFHI, 8'h04, w);

        issue(FUNC_MTHI, 8'h5A, 8'h00, w);
        check("mthi_no_busy", bus.busy, 1'b0);
        read("mthi_fwd", FUNC_MFHI, 8'h5A, w);
        issue(FUNC_MTLO, 8'hA5, 8'h00, w);
        read("mtlo_hi_kept", FUNC_MFHI, 8'h5A, w);
        read("mtlo_lo", FUNC_MFLO, 8'hA5, w);

        issue(FUNC_ADD, 8'h11, 8'h22, w);
        check("add_ignored_busy", bus.busy, 1'b0);
        check("add_ignored_ready", bus.req_ready, 1'b1);
        read("add_hi_kept", FUNC_MFHI, 8'h5A, w);

        issue(FUNC_MULU, 8'hFF, 8'hFF, w);
        read("mulu_held_lo", FUNC_MFLO, 8'h01, w);
        check("mulu_held_wait", w, DATA_W + 1);
        read("mulu_hi", FUNC_MFHI, 8'hFE, w);

        issue(FUNC_DIVU, 8'h64, 8'h07, w);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_ready", bus.req_ready, 1'b1);
        read("abort_hi", FUNC_MFHI, 8'h00, w);
        read("abort_lo", FUNC_MFLO, 8'h00, w);

        muldiv("mulu_3x4", FUNC_MULU, 8'h03, 8'h04);
        read("mulu34_lo", FUNC_MFLO, 8'h0C, w);
        read("mulu34_hi", FUNC_MFHI, 8'h00, w);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
